mem_arbiter: RTL

Two-port arbiter sharing the single memory port between the CPU control sequencer and a debug/loader requester. It serialises accesses, drives the memory strobes for a fixed multi-cycle access window, and returns read data with a one-cycle acknowledge. While a CPU access is pending it stalls the CPU sequencer, which freezes its microcode state. It sits between the control/ALU address path and the memory device.

---
 rtl/mem_arbiter_if.sv | 58 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the CPU port, debug port and memory port signals
//               shared between mem_arbiter and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    // CPU requester port
    logic        c_req;
    logic        c_write;
    logic [3:0]  c_size;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_ack;
    logic        c_stall;
    // Debug / loader requester port
    logic        d_req;
    logic        d_write;
    logic [3:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    // Memory device port
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_size;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_rdata;
    // Ownership indicator
    logic        grant_d;

    // Arbiter side: consumes requests and memory read data
    modport slave (
        input  c_req, c_write, c_size, c_addr, c_wdata,
        input  d_req, d_write, d_size, d_addr, d_wdata,
        input  m_rdata,
        output c_rdata, c_ack, c_stall,
        output d_rdata, d_ack,
        output m_addr, m_wdata, m_size, m_read, m_write,
        output grant_d
    );

    // Environment side: requesters plus memory device
    modport master (
        output c_req, c_write, c_size, c_addr, c_wdata,
        output d_req, d_write, d_size, d_addr, d_wdata,
        output m_rdata,
        input  c_rdata, c_ack, c_stall,
        input  d_rdata, d_ack,
        input  m_addr, m_wdata, m_size, m_read, m_write,
        input  grant_d
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between the CPU sequencer and a
//               debug/loader requester. Round-robin arbitration in IDLE,
//               fixed MEM_CYCLES strobe window, one-cycle ack with read data.
//               MEM_CYCLES legal range is 1..255 (8-bit down-counter).
//               Optional macro MEM_ARB_DEBUG_PRIO_EN: debug port gets strict
//               priority over the CPU (for halted-CPU program loading).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACCESS   = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;
    localparam logic [7:0] c_CNT_LOAD = 8'(MEM_CYCLES - 1);

    logic [1:0]  r_state,   w_state;
    logic [7:0]  r_cnt,     w_cnt;
    logic        r_last,    w_last;     // 1 = debug was granted last
    logic        r_grant_d, w_grant_d;
    logic [31:0] r_m_addr,  w_m_addr;
    logic [31:0] r_m_wdata, w_m_wdata;
    logic [3:0]  r_m_size,  w_m_size;
    logic        r_m_read,  w_m_read;
    logic        r_m_write, w_m_write;
    logic        r_c_ack,   w_c_ack;
    logic        r_d_ack,   w_d_ack;
    logic [31:0] r_c_rdata, w_c_rdata;
    logic [31:0] r_d_rdata, w_d_rdata;
    logic        w_pick_d;
    logic        w_sel_write;

    // Winner selection for a request seen in IDLE
    always_comb begin
`ifdef MEM_ARB_DEBUG_PRIO_EN
        w_pick_d = bus.d_req;
`else
        // On a tie the port that did not win last time is served
        w_pick_d = bus.d_req & (~bus.c_req | ~r_last);
`endif
        w_sel_write = w_pick_d ? bus.d_write : bus.c_write;
    end

    // Next-state and next-output computation
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_last    = r_last;
        w_grant_d = r_grant_d;
        w_m_addr  = r_m_addr;
        w_m_wdata = r_m_wdata;
        w_m_size  = r_m_size;
        w_m_read  = r_m_read;
        w_m_write = r_m_write;
        w_c_ack   = 1'b0;
        w_d_ack   = 1'b0;
        w_c_rdata = r_c_rdata;
        w_d_rdata = r_d_rdata;
        case (r_state)
            c_IDLE: begin
                if (bus.c_req || bus.d_req) begin
                    w_state   = c_ACCESS;
                    w_grant_d = w_pick_d;
                    w_last    = w_pick_d;
                    w_m_addr  = w_pick_d ? bus.d_addr  : bus.c_addr;
                    w_m_wdata = w_pick_d ? bus.d_wdata : bus.c_wdata;
                    w_m_size  = w_pick_d ? bus.d_size  : bus.c_size;
                    w_m_read  = ~w_sel_write;
                    w_m_write = w_sel_write;
                    w_cnt     = c_CNT_LOAD;
                end
            end
            c_ACCESS: begin
                if (r_cnt == 8'd0) begin
                    w_state   = c_DONE;
                    w_m_read  = 1'b0;
                    w_m_write = 1'b0;
                    // Only reads update the winner's data register
                    if (r_m_read) begin
                        if (r_grant_d) w_d_rdata = bus.m_rdata;
                        else           w_c_rdata = bus.m_rdata;
                    end
                    if (r_grant_d) w_d_ack = 1'b1;
                    else           w_c_ack = 1'b1;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            c_DONE: begin
                w_state = c_IDLE;
            end
            default: begin
                w_state   = c_IDLE;
                w_m_read  = 1'b0;
                w_m_write = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 8'd0;
            r_last    <= 1'b1;
            r_grant_d <= 1'b0;
            r_m_addr  <= 32'd0;
            r_m_wdata <= 32'd0;
            r_m_size  <= 4'd0;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_c_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_c_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_last    <= w_last;
            r_grant_d <= w_grant_d;
            r_m_addr  <= w_m_addr;
            r_m_wdata <= w_m_wdata;
            r_m_size  <= w_m_size;
            r_m_read  <= w_m_read;
            r_m_write <= w_m_write;
            r_c_ack   <= w_c_ack;
            r_d_ack   <= w_d_ack;
            r_c_rdata <= w_c_rdata;
            r_d_rdata <= w_d_rdata;
        end
    end

    assign bus.c_stall = bus.c_req & ~r_c_ack;
    assign bus.c_ack   = r_c_ack;
    assign bus.d_ack   = r_d_ack;
    assign bus.c_rdata = r_c_rdata;
    assign bus.d_rdata = r_d_rdata;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_size  = r_m_size;
    assign bus.m_read  = r_m_read;
    assign bus.m_write = r_m_write;
    assign bus.grant_d = r_grant_d;

endmodule
`default_nettype wire
